pipe_sel_mux: RTL and testbench
===============================

// Module: pipe_sel_mux
// PURPOSE
//   Parametrised N:1 operand-select multiplexer with a registered, handshaked output stage.
//   Generalises the fixed 2:1 32-bit datapath muxes to NUM_IN inputs of WIDTH bits.
//   Adds valid/ready flow control and a 2-entry skid buffer, so a mux can sit between
//   pipeline stages without creating a combinational ready path.
//   Flags out-of-range selects instead of silently aliasing them.
// PARAMETERS
//   WIDTH   32                 data width of each input and of the output
//   NUM_IN  4                  number of selectable inputs, >= 2
//   SEL_W   $clog2(NUM_IN)     select width; derived, never overridden
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high reset
//   in_data    in   NUM_IN*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
//   in_sel     in   SEL_W         select, sampled with in_data
//   in_valid   in   1             upstream beat present
//   in_ready   out  1             block can accept a beat this cycle
//   out_data   out  WIDTH         selected data
//   out_sel    out  SEL_W         select that produced out_data
//   out_err    out  1             1 = in_sel was >= NUM_IN for this beat
//   out_valid  out  1             output beat present
//   out_ready  in   1             downstream accepts
// BEHAVIOUR
//   - Handshakes:
//       - Accept on the rising edge where in_valid && in_ready.
//       - Emit on the rising edge where out_valid && out_ready.
//   - Selection is done at accept time and stored as {data, sel, err}.
//       - in_sel < NUM_IN: data = input in_sel, err = 0.
//       - in_sel >= NUM_IN (only possible if NUM_IN is not a power of 2): data = 0, err = 1.
//   - Storage:
//       - Main register M drives the out_* ports.
//       - Skid register S holds one extra beat.
//   - States, with transitions evaluated per edge:
//       - EMPTY: out_valid = 0, in_ready = 1.
//           - accept -> ONE, beat written into M.
//       - ONE: out_valid = 1, in_ready = 1.
//           - accept and emit   -> ONE, new beat into M.
//           - accept, no emit   -> FULL, new beat into S.
//           - emit, no accept   -> EMPTY.
//           - neither           -> ONE, M held.
//       - FULL: out_valid = 1, in_ready = 0.
//           - emit -> ONE, S moves to M.
//           - no emit -> FULL, M and S held.
//   - in_ready is a registered function of state (!FULL). There is no combinational
//     path from out_ready to in_ready.
//   - Latency is 1 cycle: a beat accepted at edge n is visible on out_* after edge n
//     when the block was EMPTY, or when ONE with a simultaneous emit.
//   - Throughput is 1 beat per cycle whenever out_ready stays high.
//   - Order is preserved strictly FIFO; no beat is dropped or duplicated.
//   - out_data, out_sel and out_err stay stable while out_valid && !out_ready.
//   - in_data and in_sel are ignored when in_valid = 0 or in_ready = 0.
//   - Reset (synchronous, any state, including mid-stall):
//       - Next state EMPTY.
//       - out_valid = 0, out_data = 0, out_sel = 0, out_err = 0.
//       - in_ready = 0 while reset is high, 1 on the first cycle after reset drops.
//       - Buffered beats are discarded.
//       - No accept occurs on an edge where reset is high.
// TESTING
//   1. NUM_IN=4, WIDTH=32, inputs {0xA0,0xB1,0xC2,0xD3}, sel=2, valid pulse, out_ready=1
//      -> next cycle out_data=0xC2, out_sel=2, out_err=0, out_valid=1 for exactly 1 cycle.
//   2. Stream sel=0,1,2,3 back-to-back, out_ready=1
//      -> 4 consecutive output beats 0xA0,0xB1,0xC2,0xD3; in_ready stays 1 throughout.
//   3. out_ready=0, send 3 beats
//      -> 2 accepted; in_ready=0 after the 2nd; out_data held at beat 1.
//      Then out_ready=1 -> beats 1, 2 emitted in order, in_ready returns to 1.
//   4. NUM_IN=3, SEL_W=2, sel=3
//      -> out_data=0, out_err=1, out_sel=3; the following sel=1 beat has out_err=0.
//   5. FULL state, reset for 1 cycle
//      -> out_valid=0 and all out_* = 0 after that edge; in_ready=0 during reset, 1 after.
//      Then 1 beat sent -> that beat alone emerges.
//   6. Random valid/ready over 10k cycles vs a scoreboard
//      -> no loss or reorder; out_* stable on every stalled cycle.

Source files
------------

// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: N:1 operand-select mux with a registered valid/ready output
// stage. A 2-entry skid buffer (main M + skid S) keeps in_ready free of any
// combinational dependence on out_ready.
module pipe_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  m_data_q;
  logic [SEL_W-1:0]  m_sel_q;
  logic              m_err_q;
  logic [WIDTH-1:0]  s_data_q;
  logic [SEL_W-1:0]  s_sel_q;
  logic              s_err_q;

  logic [WIDTH-1:0]  beat_data_d;
  logic              beat_err_d;
  logic              accept;
  logic              emit;

  // Select the addressed input; selects with no matching input flag an error.
  always_comb begin
    beat_data_d = '0;
    beat_err_d  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        beat_data_d = in_data[k*WIDTH +: WIDTH];
        beat_err_d  = 1'b0;
      end
    end
  end

  // Registered ready is 1 straight after reset, so reset masks it here to
  // hold in_ready low for the whole time reset is asserted.
  assign in_ready  = in_ready_q & ~reset;
  assign accept    = in_valid & in_ready_q & ~reset;
  assign emit      = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = m_data_q;
  assign out_sel   = m_sel_q;
  assign out_err   = m_err_q;

  // Skid-buffer FSM: M feeds the outputs, S catches one beat while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_data_q    <= '0;
      m_sel_q     <= '0;
      m_err_q     <= 1'b0;
      s_data_q    <= '0;
      s_sel_q     <= '0;
      s_err_q     <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_data_q    <= beat_data_d;
            m_sel_q     <= in_sel;
            m_err_q     <= beat_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_data_q <= beat_data_d;
            m_sel_q  <= in_sel;
            m_err_q  <= beat_err_d;
          end else if (accept) begin
            s_data_q   <= beat_data_d;
            s_sel_q    <= in_sel;
            s_err_q    <= beat_err_d;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (emit) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            m_data_q   <= s_data_q;
            m_sel_q    <= s_sel_q;
            m_err_q    <= s_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: directed vector table on a 4-input instance,
// directed out-of-range select on a 3-input instance, then a randomized
// run on the 3-input instance against a queue-based reference model.
module tb_pipe_sel_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-input instance
  logic         a_rst, a_valid, a_ordy, a_ir, a_ov, a_oerr;
  logic [127:0] a_data;
  logic [1:0]   a_sel, a_osel;
  logic [31:0]  a_od;

  // 3-input instance
  logic         b_rst, b_valid, b_ordy, b_ir, b_ov, b_oerr;
  logic [95:0]  b_data;
  logic [1:0]   b_sel, b_osel;
  logic [31:0]  b_od;

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .reset(a_rst), .in_data(a_data), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ir), .out_data(a_od), .out_sel(a_osel),
    .out_err(a_oerr), .out_valid(a_ov), .out_ready(a_ordy)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .clk(clk), .reset(b_rst), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ir), .out_data(b_od), .out_sel(b_osel),
    .out_err(b_oerr), .out_valid(b_ov), .out_ready(b_ordy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic        dchk;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } beat_t;

  vec_t  vt[18];
  beat_t q[$];
  beat_t nb;

  logic [31:0] w[3];
  logic [31:0] prev_d;
  logic [1:0]  prev_s;
  logic        prev_e;
  logic        prev_stall;
  logic        acc, emt;

  initial begin
    //          rst  v    sel    ordy  ov   ir   dchk data   sel   err
    vt[0]  = '{1'b1,1'b0,2'd0,1'b1, 1'b0,1'b0,1'b1,32'h0, 2'd0,1'b0}; // reset
    vt[1]  = '{1'b0,1'b1,2'd2,1'b1, 1'b1,1'b1,1'b1,32'hC2,2'd2,1'b0}; // single beat
    vt[2]  = '{1'b0,1'b0,2'd0,1'b1, 1'b0,1'b1,1'b0,32'h0, 2'd0,1'b0}; // valid for 1 cycle only
    vt[3]  = '{1'b0,1'b1,2'd0,1'b1, 1'b1,1'b1,1'b1,32'hA0,2'd0,1'b0}; // stream
    vt[4]  = '{1'b0,1'b1,2'd1,1'b1, 1'b1,1'b1,1'b1,32'hB1,2'd1,1'b0};
    vt[5]  = '{1'b0,1'b1,2'd2,1'b1, 1'b1,1'b1,1'b1,32'hC2,2'd2,1'b0};
    vt[6]  = '{1'b0,1'b1,2'd3,1'b1, 1'b1,1'b1,1'b1,32'hD3,2'd3,1'b0};
    vt[7]  = '{1'b0,1'b0,2'd0,1'b1, 1'b0,1'b1,1'b0,32'h0, 2'd0,1'b0};
    vt[8]  = '{1'b0,1'b1,2'd0,1'b0, 1'b1,1'b1,1'b1,32'hA0,2'd0,1'b0}; // stall fill
    vt[9]  = '{1'b0,1'b1,2'd1,1'b0, 1'b1,1'b0,1'b1,32'hA0,2'd0,1'b0};
    vt[10] = '{1'b0,1'b1,2'd2,1'b0, 1'b1,1'b0,1'b1,32'hA0,2'd0,1'b0}; // refused
    vt[11] = '{1'b0,1'b0,2'd0,1'b1, 1'b1,1'b1,1'b1,32'hB1,2'd1,1'b0}; // drain
    vt[12] = '{1'b0,1'b0,2'd0,1'b1, 1'b0,1'b1,1'b0,32'h0, 2'd0,1'b0};
    vt[13] = '{1'b0,1'b1,2'd3,1'b0, 1'b1,1'b1,1'b1,32'hD3,2'd3,1'b0}; // fill again
    vt[14] = '{1'b0,1'b1,2'd0,1'b0, 1'b1,1'b0,1'b1,32'hD3,2'd3,1'b0};
    vt[15] = '{1'b1,1'b1,2'd1,1'b0, 1'b0,1'b0,1'b1,32'h0, 2'd0,1'b0}; // reset from FULL
    vt[16] = '{1'b0,1'b1,2'd1,1'b0, 1'b1,1'b1,1'b1,32'hB1,2'd1,1'b0};
    vt[17] = '{1'b0,1'b0,2'd0,1'b1, 1'b0,1'b1,1'b0,32'h0, 2'd0,1'b0}; // that beat alone

    a_data = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    a_rst = 1'b1; a_valid = 1'b0; a_sel = '0; a_ordy = 1'b0;
    b_data = {32'hC2, 32'hB1, 32'hA0};
    b_rst = 1'b1; b_valid = 1'b0; b_sel = '0; b_ordy = 1'b0;

    // Directed table on the 4-input instance
    for (int i = 0; i < 18; i++) begin
      a_rst = vt[i].rst; a_valid = vt[i].valid; a_sel = vt[i].sel; a_ordy = vt[i].ordy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), 32'(a_ov), 32'(vt[i].e_ov));
      check($sformatf("vec%0d in_ready", i), 32'(a_ir), 32'(vt[i].e_ir));
      if (vt[i].dchk) begin
        check($sformatf("vec%0d out_data", i), a_od, vt[i].e_data);
        check($sformatf("vec%0d out_sel", i), 32'(a_osel), 32'(vt[i].e_sel));
        check($sformatf("vec%0d out_err", i), 32'(a_oerr), 32'(vt[i].e_err));
      end
    end

    // Out-of-range select on the 3-input instance
    b_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    b_rst = 1'b0; b_valid = 1'b1; b_sel = 2'd3; b_ordy = 1'b1;
    @(posedge clk); @(negedge clk);
    check("oor out_valid", 32'(b_ov), 32'd1);
    check("oor out_data", b_od, 32'h0);
    check("oor out_sel", 32'(b_osel), 32'd3);
    check("oor out_err", 32'(b_oerr), 32'd1);
    b_sel = 2'd1;
    @(posedge clk); @(negedge clk);
    check("after-oor out_data", b_od, 32'hB1);
    check("after-oor out_sel", 32'(b_osel), 32'd1);
    check("after-oor out_err", 32'(b_oerr), 32'd0);
    b_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("after-oor drained", 32'(b_ov), 32'd0);

    // Randomized run against the occupancy/queue model
    b_rst = 1'b1;
    @(posedge clk);
    q.delete();
    prev_stall = 1'b0;
    prev_d = '0; prev_s = '0; prev_e = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check("rnd out_valid", 32'(b_ov), 32'(q.size() > 0));
      check("rnd in_ready", 32'(!b_rst && q.size() < 2), 32'(b_ir));
      if (q.size() > 0) begin
        check("rnd out_data", b_od, q[0].d);
        check("rnd out_sel", 32'(b_osel), 32'(q[0].s));
        check("rnd out_err", 32'(b_oerr), 32'(q[0].e));
      end
      if (prev_stall) begin
        check("rnd stall data", b_od, prev_d);
        check("rnd stall sel", 32'(b_osel), 32'(prev_s));
        check("rnd stall err", 32'(b_oerr), 32'(prev_e));
      end

      for (int k = 0; k < 3; k++) w[k] = $urandom;
      b_data  = {w[2], w[1], w[0]};
      b_sel   = 2'($urandom_range(0, 3));
      b_valid = ($urandom_range(0, 9) < 6);
      b_ordy  = ($urandom_range(0, 9) < 6);
      b_rst   = ($urandom_range(0, 499) == 0);

      acc = b_valid && !b_rst && q.size() < 2;
      emt = q.size() > 0 && b_ordy && !b_rst;
      nb.s = b_sel;
      nb.e = (b_sel >= 2'd3);
      nb.d = nb.e ? 32'h0 : w[b_sel];
      prev_stall = (q.size() > 0) && !b_ordy && !b_rst;
      prev_d = b_od; prev_s = b_osel; prev_e = b_oerr;

      @(posedge clk);
      if (b_rst) begin
        q.delete();
      end else begin
        if (emt) void'(q.pop_front());
        if (acc) q.push_back(nb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
